// File: rtl/system_widths_pkg.sv
// -----------------------------------------------------------------------------
// system_widths_pkg
//   Shared widths and writeback payload type for the register-file write path.
//   Contents:
//     REG_W      register data width
//     RF_ADDR_W  register-file address width
//     wb_req_t   one writeback result {waddr, wdata}
// -----------------------------------------------------------------------------
package system_widths_pkg;

   localparam int REG_W     = 32;
   localparam int RF_ADDR_W = 5;

   typedef struct packed {
      logic [4:0]       waddr;
      logic [REG_W-1:0] wdata;
   } wb_req_t;

endpackage

// File: rtl/wb_fifo.sv
// -----------------------------------------------------------------------------
// wb_fifo
//   In-order circular buffer for long-latency writeback results.
//   Ports:
//     clk, resetN   clock / asynchronous active-low reset (clears pointers, count)
//     push, din     enqueue din when push && !full
//     pop           dequeue head when pop && !empty
//     full, empty   derived from the registered count
//     count         occupancy, 0..DEPTH
//     head          oldest entry (valid while !empty)
//   DEPTH must be a power of two so pointers wrap by natural overflow.
// -----------------------------------------------------------------------------
module wb_fifo
   import system_widths_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       resetN,
   input  logic                       push,
   input  wb_req_t                    din,
   input  logic                       pop,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count,
   output wb_req_t                    head
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW-1:0] PTR_ONE = AW'(1);
   localparam logic [AW:0]   CNT_ONE = (AW + 1)'(1);
   localparam logic [AW:0]   CNT_MAX = (AW + 1)'(DEPTH);

   wb_req_t       mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          push_ok;
   logic          pop_ok;

   assign full    = (count == CNT_MAX);
   assign empty   = (count == '0);
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;
   assign head    = mem[rd_ptr];

   // Storage carries no reset: entries are only observable through the
   // pointers, which are reset.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_ptr] <= din;
      end
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (pop_ok) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
         case ({push_ok, pop_ok})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/wb_arbiter.sv
// -----------------------------------------------------------------------------
// wb_arbiter
//   Writeback stage in front of the register-file write port. Merges
//   single-cycle ALU results (priority) with long-latency LSU/MUL results that
//   are buffered in an in-order FIFO, producing one registered write per cycle.
//
//   Ports:
//     clk, resetN                       clock / asynchronous active-low reset
//     alu_valid/alu_ready/alu_waddr/alu_wdata   ALU result handshake
//     lsu_valid/lsu_ready/lsu_waddr/lsu_wdata   LSU result handshake (to FIFO)
//     rf_wen/rf_waddr/rf_wdata          registered register-file write
//     fifo_count                        LSU FIFO occupancy, 0..FIFO_DEPTH
//     busy                              fifo_count != 0 || rf_wen
//
//   Handshake: a result transfers on a rising clk edge where valid && ready.
//   A producer holding valid without ready keeps waddr/wdata stable. Both
//   ready outputs depend only on registered state.
//
//   Build option WB_ARB_FAIR_EN: when defined, a starve counter forces the
//   FIFO head into the slot after STARVE_MAX consecutive ALU wins with the
//   FIFO non-empty. When undefined, the ALU has strict priority and
//   alu_ready is constant 1.
// -----------------------------------------------------------------------------
module wb_arbiter
   import system_widths_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int STARVE_MAX = 3
) (
   input  logic                         clk,
   input  logic                         resetN,
   input  logic                         alu_valid,
   output logic                         alu_ready,
   input  logic [RF_ADDR_W-1:0]         alu_waddr,
   input  logic [REG_W-1:0]             alu_wdata,
   input  logic                         lsu_valid,
   output logic                         lsu_ready,
   input  logic [RF_ADDR_W-1:0]         lsu_waddr,
   input  logic [REG_W-1:0]             lsu_wdata,
   output logic                         rf_wen,
   output logic [RF_ADDR_W-1:0]         rf_waddr,
   output logic [REG_W-1:0]             rf_wdata,
   output logic [$clog2(FIFO_DEPTH):0]  fifo_count,
   output logic                         busy
);

   // Reject unusable configurations at elaboration time.
   if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || STARVE_MAX < 1)
   begin : g_bad_params
      $error("wb_arbiter: FIFO_DEPTH must be a power of two >= 2, STARVE_MAX >= 1");
   end

   wb_req_t lsu_req;
   wb_req_t head;
   logic    full;
   logic    empty;
   logic    push;
   logic    pop;
   logic    alu_fire;
   logic    force_lsu;

   assign lsu_req = {lsu_waddr, lsu_wdata};

   wb_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk    (clk),
      .resetN (resetN),
      .push   (push),
      .din    (lsu_req),
      .pop    (pop),
      .full   (full),
      .empty  (empty),
      .count  (fifo_count),
      .head   (head)
   );

`ifdef WB_ARB_FAIR_EN
   localparam int SW = $clog2(STARVE_MAX + 1);
   localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
   localparam logic [SW-1:0] STARVE_ONE = SW'(1);

   logic [SW-1:0] starve_cnt;

   // The counter only advances while the FIFO holds something and clears on
   // every dequeue, so reaching the limit implies a head exists; the !empty
   // term just keeps the force self-evidently safe.
   assign force_lsu = (starve_cnt == STARVE_LIM) && !empty;

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         starve_cnt <= '0;
      end else if (pop) begin
         starve_cnt <= '0;
      end else if (alu_fire && !empty) begin
         starve_cnt <= starve_cnt + STARVE_ONE;
      end
   end
`else
   assign force_lsu = 1'b0;
`endif

   assign alu_ready = !force_lsu;
   assign lsu_ready = !full;

   // Grant: an ALU transfer owns the slot; otherwise the FIFO head drains.
   assign alu_fire = alu_valid && alu_ready;
   assign pop      = !alu_fire && !empty;
   assign push     = lsu_valid && lsu_ready;

   // x0 results consume the slot but never raise rf_wen.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         rf_wen   <= 1'b0;
         rf_waddr <= '0;
         rf_wdata <= '0;
      end else if (alu_fire) begin
         rf_wen   <= (alu_waddr != '0);
         rf_waddr <= alu_waddr;
         rf_wdata <= alu_wdata;
      end else if (pop) begin
         rf_wen   <= (head.waddr != '0);
         rf_waddr <= head.waddr;
         rf_wdata <= head.wdata;
      end else begin
         rf_wen   <= 1'b0;
      end
   end

   assign busy = (fifo_count != '0) || rf_wen;

endmodule

// File: tb/tb_wb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_wb_arbiter
//   Directed plus randomized checks of wb_arbiter against a queue-based
//   reference model of the writeback rules. Honours WB_ARB_FAIR_EN.
// -----------------------------------------------------------------------------
module tb_wb_arbiter;
   import system_widths_pkg::*;

   localparam int DEPTH = 4;
   localparam int SMAX  = 3;
   localparam int W     = $bits(wb_req_t);
`ifdef WB_ARB_FAIR_EN
   localparam bit FAIR = 1'b1;
`else
   localparam bit FAIR = 1'b0;
`endif

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic resetN = 1'b0;
   always #5 clk = ~clk;

   logic                  alu_valid;
   logic                  alu_ready;
   logic [RF_ADDR_W-1:0]  alu_waddr;
   logic [REG_W-1:0]      alu_wdata;
   logic                  lsu_valid;
   logic                  lsu_ready;
   logic [RF_ADDR_W-1:0]  lsu_waddr;
   logic [REG_W-1:0]      lsu_wdata;
   logic                  rf_wen;
   logic [RF_ADDR_W-1:0]  rf_waddr;
   logic [REG_W-1:0]      rf_wdata;
   logic [$clog2(DEPTH):0] fifo_count;
   logic                  busy;

   wb_arbiter #(
      .FIFO_DEPTH (DEPTH),
      .STARVE_MAX (SMAX)
   ) dut (
      .clk        (clk),
      .resetN     (resetN),
      .alu_valid  (alu_valid),
      .alu_ready  (alu_ready),
      .alu_waddr  (alu_waddr),
      .alu_wdata  (alu_wdata),
      .lsu_valid  (lsu_valid),
      .lsu_ready  (lsu_ready),
      .lsu_waddr  (lsu_waddr),
      .lsu_wdata  (lsu_wdata),
      .rf_wen     (rf_wen),
      .rf_waddr   (rf_waddr),
      .rf_wdata   (rf_wdata),
      .fifo_count (fifo_count),
      .busy       (busy)
   );

   // ---------------- scoreboard / reference model ----------------
   int vectors     = 0;
   int miscompares = 0;

   logic [W-1:0]         exp_q[$];   // model of the LSU FIFO contents
   logic                 m_wen;
   logic [RF_ADDR_W-1:0] m_waddr;
   logic [REG_W-1:0]     m_wdata;
   int                   m_starve;
   bit                   m_alu_fire;
   bit                   m_push;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      exp_q.delete();
      m_wen      = 1'b0;
      m_waddr    = '0;
      m_wdata    = '0;
      m_starve   = 0;
      m_alu_fire = 1'b0;
      m_push     = 1'b0;
   endtask

   // ---------------- driver tasks ----------------
   task automatic set_alu(input logic v, input logic [4:0] a, input logic [31:0] d);
      alu_valid = v;
      alu_waddr = a;
      alu_wdata = d;
   endtask

   task automatic set_lsu(input logic v, input logic [4:0] a, input logic [31:0] d);
      lsu_valid = v;
      lsu_waddr = a;
      lsu_wdata = d;
   endtask

   // One clock: check outputs at the falling edge against the model, advance
   // the model with the inputs present at the coming rising edge, return #1
   // after that edge so the caller can drive the next inputs.
   task automatic cycle();
      bit      ar, lr, fire, pop, push;
      wb_req_t h;
      @(negedge clk);
      lr = (exp_q.size() != DEPTH);
      ar = !(FAIR && (m_starve == SMAX) && (exp_q.size() != 0));
      chk("alu_ready", alu_ready, ar);
      chk("lsu_ready", lsu_ready, lr);
      chk("fifo_count", fifo_count, exp_q.size());
      chk("rf_wen", rf_wen, m_wen);
      if (m_wen) begin
         chk("rf_waddr", rf_waddr, m_waddr);
         chk("rf_wdata", rf_wdata, m_wdata);
      end
      chk("busy", busy, (exp_q.size() != 0) || m_wen);

      fire = alu_valid && ar;
      pop  = !fire && (exp_q.size() != 0);
      push = lsu_valid && lr;
      if (fire) begin
         m_wen   = (alu_waddr != 0);
         m_waddr = alu_waddr;
         m_wdata = alu_wdata;
      end else if (pop) begin
         h       = exp_q[0];
         m_wen   = (h.waddr != 0);
         m_waddr = h.waddr;
         m_wdata = h.wdata;
      end else begin
         m_wen = 1'b0;
      end
      if (pop) m_starve = 0;
      else if (fire && exp_q.size() != 0) m_starve++;
      if (pop) void'(exp_q.pop_front());
      if (push) exp_q.push_back({lsu_waddr, lsu_wdata});
      m_alu_fire = fire;
      m_push     = push;
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_state(input string pfx);
      chk({pfx, "_rf_wen"}, rf_wen, 1'b0);
      chk({pfx, "_rf_waddr"}, rf_waddr, 5'd0);
      chk({pfx, "_rf_wdata"}, rf_wdata, 32'd0);
      chk({pfx, "_fifo_count"}, fifo_count, 0);
      chk({pfx, "_alu_ready"}, alu_ready, 1'b1);
      chk({pfx, "_lsu_ready"}, lsu_ready, 1'b1);
      chk({pfx, "_busy"}, busy, 1'b0);
   endtask

   // Watchdog: the sequence is fixed-length, so this only fires on a hang.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- directed + random sequence ----------------
   initial begin
      int n;
      set_alu(1'b0, 5'd0, 32'd0);
      set_lsu(1'b0, 5'd0, 32'd0);
      model_reset();
      resetN = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_reset_state("reset");
      #2 resetN = 1'b1;
      @(posedge clk);
      #1;

      // 1: single ALU write, visible the next cycle, then gone.
      set_alu(1'b1, 5'd3, 32'hA5);
      cycle();
      set_alu(1'b0, 5'd0, 32'd0);
      cycle();
      cycle();

      // 2: three LSU pushes back-to-back with the ALU idle.
      for (int i = 0; i < 3; i++) begin
         set_lsu(1'b1, 5'(5 + i), $urandom);
         cycle();
      end
      set_lsu(1'b0, 5'd0, 32'd0);
      repeat (4) cycle();

      // 3: ALU every cycle while the LSU fills the FIFO.
      set_alu(1'b1, 5'($urandom_range(1, 31)), $urandom);
      set_lsu(1'b1, 5'($urandom_range(1, 31)), $urandom);
      for (int i = 0; i < 12; i++) begin
         cycle();
         if (m_alu_fire) set_alu(1'b1, 5'($urandom_range(1, 31)), $urandom);
         if (m_push) set_lsu(1'b1, 5'($urandom_range(1, 31)), $urandom);
      end
      chk("fill_count", fifo_count, DEPTH);
      chk("fill_lsu_ready", lsu_ready, 1'b0);

      // 6: full FIFO, ALU idle: the pending push is refused while the head
      // drains; keep pushing until 10 more entries have gone through.
      set_alu(1'b0, 5'd0, 32'd0);
      cycle();
      chk("full_pop_count", fifo_count, DEPTH - 1);
      n = 0;
      for (int c = 0; c < 60 && n < 10; c++) begin
         if (m_push) begin
            n++;
            set_lsu(1'b1, 5'($urandom_range(1, 31)), $urandom);
         end
         cycle();
      end
      chk("wrap_pushes", n, 10);
      set_lsu(1'b0, 5'd0, 32'd0);
      repeat (DEPTH + 2) cycle();

      // 4: both producers write x0 in the same cycle.
      set_alu(1'b1, 5'd0, $urandom);
      set_lsu(1'b1, 5'd0, $urandom);
      cycle();
      set_alu(1'b0, 5'd0, 32'd0);
      set_lsu(1'b0, 5'd0, 32'd0);
      repeat (3) cycle();
      chk("x0_count", fifo_count, 0);
      chk("x0_wen", rf_wen, 1'b0);

      // 5: asynchronous reset mid-cycle with a populated FIFO and a write
      // pending on the output.
      for (int i = 0; i < 3; i++) begin
         set_alu(1'b1, 5'(10 + i), $urandom);
         set_lsu(1'b1, 5'(20 + i), $urandom);
         cycle();
      end
      set_alu(1'b0, 5'd0, 32'd0);
      set_lsu(1'b0, 5'd0, 32'd0);
      #1;
      chk("pre_reset_count", fifo_count, 3);
      chk("pre_reset_wen", rf_wen, 1'b1);
      resetN = 1'b0;
      #1;
      check_reset_state("async_reset");
      model_reset();
      @(negedge clk);
      #2 resetN = 1'b1;
      @(posedge clk);
      #1;
      repeat (3) cycle();

      // Random traffic with hold-while-stalled producers.
      for (int i = 0; i < 400; i++) begin
         if (!alu_valid || m_alu_fire)
            set_alu(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom);
         if (!lsu_valid || m_push)
            set_lsu(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom);
         cycle();
      end
      set_alu(1'b0, 5'd0, 32'd0);
      set_lsu(1'b0, 5'd0, 32'd0);
      repeat (DEPTH + 3) cycle();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
